// File: rtl/clk_enable_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_enable_gen
// Purpose  : Lock-qualified, runtime-programmable clock-enable generator.
//            Runs in the fast PLL output domain. It provides NUM_CH
//            independent divide-by-N enable channels. Each channel produces a
//            wrap pulse (ce) and a mid-period pulse (ce_half). All enables are
//            held off until the PLL lock has been stable for LOCK_CYCLES.
// Ports    : clkin     - fast PLL clock (sole clock)
//            reset_n   - asynchronous active-low reset
//            pll_lock  - asynchronous PLL lock, synchronised internally
//            div_wr    - single-cycle divisor write strobe
//            div_ch    - target channel of the write
//            div_val   - new divisor (0 disables the channel)
//            div_ack   - per-channel pulse: new divisor now in effect
//            div_busy  - per-channel write pending
//            ce        - per-channel one-cycle enable at period wrap
//            ce_half   - per-channel one-cycle enable at mid-period
//            ready     - lock qualified, enables running
//            loss_cnt  - saturating count of lock losses while running
// Revision : 1.0 - initial release
// ============================================================================
module clk_enable_gen #(
    parameter int                         NUM_CH      = 3,
    parameter int                         CNT_W       = 8,
    parameter logic [NUM_CH*CNT_W-1:0]    DIV_INIT    = {8'd3, 8'd2, 8'd1},
    parameter int                         LOCK_CYCLES = 1024,
    localparam int                        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clkin,
    input  logic                reset_n,
    input  logic                pll_lock,
    input  logic                div_wr,
    input  logic [CH_W-1:0]     div_ch,
    input  logic [CNT_W-1:0]    div_val,
    output logic [NUM_CH-1:0]   div_ack,
    output logic [NUM_CH-1:0]   div_busy,
    output logic [NUM_CH-1:0]   ce,
    output logic [NUM_CH-1:0]   ce_half,
    output logic                ready,
    output logic [7:0]          loss_cnt
);

    localparam int              QW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [QW-1:0]   Q_LAST  = QW'(LOCK_CYCLES - 1);

    typedef enum logic [0:0] {
        QUALIFY = 1'b0,
        RUN     = 1'b1
    } state_t;

    state_t         r_state;
    logic [QW-1:0]  r_qual;
    logic           r_sync1;
    logic           r_sync2;

    // Per-cycle mode decode shared by all channels:
    //   w_run_go   - running and lock still good: channels count
    //   w_run_drop - running but lock lost: this edge falls back to QUALIFY
    logic           w_run_go;
    logic           w_run_drop;

    assign w_run_go   = (r_state == RUN) &&  r_sync2;
    assign w_run_drop = (r_state == RUN) && !r_sync2;
    assign ready      = (r_state == RUN);

    // ------------------------------------------------------------------------
    // Lock synchroniser and qualification state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_state  <= QUALIFY;
            r_qual   <= '0;
            loss_cnt <= 8'd0;
        end else begin
            r_sync1 <= pll_lock;
            r_sync2 <= r_sync1;
            case (r_state)
                QUALIFY: begin
                    if (r_sync2) begin
                        r_qual <= r_qual + 1'b1;
                        // Enter RUN on the same edge the count reaches LOCK_CYCLES.
                        if (r_qual == Q_LAST) begin
                            r_state <= RUN;
                        end
                    end else begin
                        r_qual <= '0;
                    end
                end
                RUN: begin
                    if (!r_sync2) begin
                        r_state <= QUALIFY;
                        r_qual  <= '0;
                        if (loss_cnt != 8'hFF) begin
                            loss_cnt <= loss_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state <= QUALIFY;
                    r_qual  <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Enable channels
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0]   r_cnt;
        logic [CNT_W-1:0]   r_div;
        logic [CNT_W-1:0]   r_pend;
        logic               r_pend_v;
        logic               r_ce;
        logic               r_half;
        logic               r_ack;
        logic               w_nz;
        logic               w_wrap;
        logic               w_mid;
        logic               w_hit;

        assign w_nz   = (r_div != '0);
        assign w_wrap = w_nz && (r_cnt == r_div - 1'b1);
        assign w_mid  = w_nz && (r_cnt == ((r_div - 1'b1) >> 1));
        // Out-of-range channel numbers match no channel and are dropped.
        assign w_hit  = div_wr && (div_ch == CH_W'(i));

        always_ff @(posedge clkin or negedge reset_n) begin
            if (!reset_n) begin
                r_cnt    <= '0;
                r_div    <= DIV_INIT[i*CNT_W +: CNT_W];
                r_pend   <= '0;
                r_pend_v <= 1'b0;
                r_ce     <= 1'b0;
                r_half   <= 1'b0;
                r_ack    <= 1'b0;
            end else begin
                r_ack <= 1'b0;
                if (w_run_go) begin
                    r_ce   <= w_wrap;
                    r_half <= w_mid;
                    // Swap divisors only at a period boundary (or when idle)
                    // so the old period always completes with its own ce.
                    if (r_pend_v && (w_wrap || !w_nz)) begin
                        r_div    <= r_pend;
                        r_cnt    <= '0;
                        r_pend_v <= 1'b0;
                        r_ack    <= 1'b1;
                    end else if (w_wrap) begin
                        r_cnt <= '0;
                    end else if (w_nz) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else if (w_run_drop) begin
                    // Lock lost: silence the channel but keep divisor and
                    // any pending write for after re-qualification.
                    r_ce   <= 1'b0;
                    r_half <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    // Not running: nothing to stay in phase with, so a
                    // pending divisor takes effect immediately.
                    r_ce   <= 1'b0;
                    r_half <= 1'b0;
                    r_cnt  <= '0;
                    if (r_pend_v) begin
                        r_div    <= r_pend;
                        r_pend_v <= 1'b0;
                        r_ack    <= 1'b1;
                    end
                end
                // A write on the apply edge becomes the next pending value.
                if (w_hit) begin
                    r_pend   <= div_val;
                    r_pend_v <= 1'b1;
                end
            end
        end

        assign ce[i]       = r_ce;
        assign ce_half[i]  = r_half;
        assign div_ack[i]  = r_ack;
        assign div_busy[i] = r_pend_v;
    end

endmodule
`default_nettype wire
